avatar_motion_ctrl: RTL and testbench

//  Multi-player avatar movement engine for the maze game. Per player: a step-rate timer,

---
 rtl/avatar_pkg.sv | 36 +++
 rtl/motion_tick_gen.sv | 29 ++
 rtl/avatar_motion_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_avatar_motion_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avatar_pkg.sv
// Shared definitions for the avatar motion engine: direction bit indices,
// lookup FSM encoding, direction priority decode and keyboard scan codes.
package avatar_pkg;

  // Bit positions inside each player's 4-bit {up,down,left,right} request nibble
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_REQ  = 1'b1
  } lk_state_t;

  // PS/2 set-2 make codes; the arrow keys follow the E0 extension prefix
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_ARROW_UP  = 8'h75;
  localparam logic [7:0] SC_ARROW_DN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RT  = 8'h74;
  localparam logic [7:0] SC_KEY_W     = 8'h1D;
  localparam logic [7:0] SC_KEY_S     = 8'h1B;
  localparam logic [7:0] SC_KEY_A     = 8'h1C;
  localparam logic [7:0] SC_KEY_D     = 8'h23;

  // One-hot pick of a single direction, up > down > left > right
  function automatic logic [3:0] dir_pick(input logic [3:0] req);
    dir_pick = 4'b0000;
    if (req[DIR_UP])         dir_pick[DIR_UP]    = 1'b1;
    else if (req[DIR_DOWN])  dir_pick[DIR_DOWN]  = 1'b1;
    else if (req[DIR_LEFT])  dir_pick[DIR_LEFT]  = 1'b1;
    else if (req[DIR_RIGHT]) dir_pick[DIR_RIGHT] = 1'b1;
  endfunction

endpackage

// File: rtl/motion_tick_gen.sv
// Per-player step-rate timer: counts 0..step_period-1 and ticks on the last
// count; a load strobe restarts the count. step_period of 0 behaves as 1.
module motion_tick_gen #(
  parameter int SPEED_W = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SPEED_W-1:0] step_period,
  input  logic               load,
  output logic               tick
);
  localparam logic [SPEED_W-1:0] ONE = 1;

  logic [SPEED_W-1:0] cnt_q;
  logic [SPEED_W-1:0] last;
  logic               at_end;

  assign last   = (step_period == '0) ? '0 : step_period - ONE;
  // >= so a shortened period mid-count wraps instead of running the full range
  assign at_end = (cnt_q >= last);
  assign tick   = at_end && !load;

  always_ff @(posedge clk) begin
    if (reset)               cnt_q <= '0;
    else if (load || at_end) cnt_q <= '0;
    else                     cnt_q <= cnt_q + ONE;
  end

endmodule

// File: rtl/avatar_motion_ctrl.sv
// Multi-player avatar movement engine with one shared, round-robin wall lookup port.
// Define AVATAR_WRAP_EN for toroidal edge wrapping; otherwise edge exits bump.
//
// state | meaning
// IDLE  | no lookup outstanding; grants the next pending player
// REQ   | wall_rd_req held with a latched cell until wall_rd_valid is sampled
module avatar_motion_ctrl
  import avatar_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 7,
  parameter int SPEED_W   = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             maze_width,
  input  logic [COORD_W-1:0]             maze_height,
  input  logic [SPEED_W-1:0]             step_period,
  input  logic [4*N_PLAYERS-1:0]         dir_req,
  input  logic [N_PLAYERS-1:0]           load,
  input  logic [COORD_W*N_PLAYERS-1:0]   load_x,
  input  logic [COORD_W*N_PLAYERS-1:0]   load_y,
  output logic                           wall_rd_req,
  output logic [COORD_W-1:0]             wall_rd_x,
  output logic [COORD_W-1:0]             wall_rd_y,
  input  logic                           wall_rd_valid,
  input  logic                           wall_rd_open,
  output logic [COORD_W*N_PLAYERS-1:0]   char_x,
  output logic [COORD_W*N_PLAYERS-1:0]   char_y,
  output logic [N_PLAYERS-1:0]           moved,
  output logic [N_PLAYERS-1:0]           bumped,
  output logic                           busy
);
  localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [COORD_W-1:0] C_ONE = 1;

  lk_state_t            st_q, st_d;
  logic [IDX_W-1:0]     gnt_q, rr_q, pick, idx_b;
  logic                 found, discard_q, done;
  int                   idx;
  logic [COORD_W-1:0]   rd_x_q, rd_y_q;
  logic [N_PLAYERS-1:0] pend, new_pend, req_vec;
  logic [COORD_W-1:0]   cand_x [N_PLAYERS];
  logic [COORD_W-1:0]   cand_y [N_PLAYERS];

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pl
    logic               tick, pend_q, mv_q, bp_q, in_b, go, fin, horiz;
    logic [3:0]         dsel;
    logic [COORD_W-1:0] px_q, py_q, tx_q, ty_q, nx, ny;

    motion_tick_gen #(.SPEED_W(SPEED_W)) u_tick (
      .clk         (clk),
      .reset       (reset),
      .step_period (step_period),
      .load        (load[p]),
      .tick        (tick)
    );

    assign horiz = dsel[DIR_LEFT] || dsel[DIR_RIGHT];

    always_comb begin
      dsel = dir_pick(dir_req[4*p +: 4]);
      nx   = px_q;
      ny   = py_q;
      if (dsel[DIR_UP])         ny = py_q - C_ONE;
      else if (dsel[DIR_DOWN])  ny = py_q + C_ONE;
      else if (dsel[DIR_LEFT])  nx = px_q - C_ONE;
      else if (dsel[DIR_RIGHT]) nx = px_q + C_ONE;
`ifdef AVATAR_WRAP_EN
      // only the moving axis wraps; a zero-sized maze still fails in_b below
      if (horiz && nx >= maze_width)
        nx = dsel[DIR_LEFT] ? maze_width - C_ONE : '0;
      if (!horiz && ny >= maze_height)
        ny = dsel[DIR_UP] ? maze_height - C_ONE : '0;
`endif
    end

    assign in_b        = (nx < maze_width) && (ny < maze_height);
    assign go          = tick && (|dsel) && !pend_q;
    assign new_pend[p] = go && in_b;
    assign fin         = done && (gnt_q == IDX_W'(p)) && !discard_q;
    assign pend[p]     = pend_q;
    assign cand_x[p]   = pend_q ? tx_q : nx;
    assign cand_y[p]   = pend_q ? ty_q : ny;

    always_ff @(posedge clk) begin
      if (reset) begin
        px_q   <= '0;
        py_q   <= '0;
        tx_q   <= '0;
        ty_q   <= '0;
        pend_q <= 1'b0;
        mv_q   <= 1'b0;
        bp_q   <= 1'b0;
      end else begin
        mv_q <= 1'b0;
        bp_q <= 1'b0;
        if (load[p]) begin
          px_q   <= load_x[COORD_W*p +: COORD_W];
          py_q   <= load_y[COORD_W*p +: COORD_W];
          pend_q <= 1'b0;
        end else begin
          if (new_pend[p]) begin
            pend_q <= 1'b1;
            tx_q   <= nx;
            ty_q   <= ny;
          end else if (fin) begin
            pend_q <= 1'b0;
          end
          if (fin && wall_rd_open) begin
            px_q <= tx_q;
            py_q <= ty_q;
            mv_q <= 1'b1;
          end
          bp_q <= (go && !in_b) || (fin && !wall_rd_open);
        end
      end
    end

    assign char_x[COORD_W*p +: COORD_W] = px_q;
    assign char_y[COORD_W*p +: COORD_W] = py_q;
    assign moved[p]                     = mv_q;
    assign bumped[p]                    = bp_q;
  end

  // Requests raised this cycle are visible to the arbiter so req rises one cycle after the tick
  assign req_vec = (pend | new_pend) & ~load;

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      idx   = (int'(rr_q) + i) % N_PLAYERS;
      idx_b = IDX_W'(idx);
      if (!found && req_vec[idx_b]) begin
        pick  = idx_b;
        found = 1'b1;
      end
    end
  end

  assign done = (st_q == LK_REQ) && wall_rd_valid;

  always_comb begin
    st_d = st_q;
    case (st_q)
      LK_IDLE: if (found) st_d = LK_REQ;
      LK_REQ:  if (wall_rd_valid) st_d = LK_IDLE;
      default: st_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= LK_IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == LK_IDLE && found) begin
        gnt_q     <= pick;
        rr_q      <= IDX_W'((int'(pick) + 1) % N_PLAYERS);
        rd_x_q    <= cand_x[pick];
        rd_y_q    <= cand_y[pick];
        discard_q <= 1'b0;
      end else if (st_q == LK_REQ && load[gnt_q]) begin
        discard_q <= 1'b1;
      end
    end
  end

  assign wall_rd_req = (st_q == LK_REQ);
  assign wall_rd_x   = rd_x_q;
  assign wall_rd_y   = rd_y_q;
  assign busy        = (|pend) || (st_q == LK_REQ);

endmodule

// File: tb/tb_avatar_motion_ctrl.sv
// Directed bench for avatar_motion_ctrl with a simple wall-memory responder
// (programmable valid delay, one optional wall cell). Honors AVATAR_WRAP_EN.
module tb_avatar_motion_ctrl;
  localparam int N  = 2;
  localparam int CW = 7;
  localparam int SW = 28;

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   maze_width, maze_height;
  logic [SW-1:0]   step_period;
  logic [4*N-1:0]  dir_req;
  logic [N-1:0]    load;
  logic [CW*N-1:0] load_x, load_y;
  logic            wall_rd_req;
  logic [CW-1:0]   wall_rd_x, wall_rd_y;
  logic            wall_rd_valid, wall_rd_open;
  logic [CW*N-1:0] char_x, char_y;
  logic [N-1:0]    moved, bumped;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  int            vdelay   = 0;
  int            wait_cnt = 0;
  logic          wall_en  = 1'b0;
  logic [CW-1:0] wall_x   = '0;
  logic [CW-1:0] wall_y   = '0;

  always #5 clk = ~clk;

  // responder: valid after vdelay cycles of req, open unless the single wall cell is hit
  assign wall_rd_valid = wall_rd_req && (wait_cnt >= vdelay);
  assign wall_rd_open  = !(wall_en && wall_rd_x == wall_x && wall_rd_y == wall_y);
  always @(negedge clk) wait_cnt <= wall_rd_req ? wait_cnt + 1 : 0;

  avatar_motion_ctrl #(.N_PLAYERS(N), .COORD_W(CW), .SPEED_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .maze_width    (maze_width),
    .maze_height   (maze_height),
    .step_period   (step_period),
    .dir_req       (dir_req),
    .load          (load),
    .load_x        (load_x),
    .load_y        (load_y),
    .wall_rd_req   (wall_rd_req),
    .wall_rd_x     (wall_rd_x),
    .wall_rd_y     (wall_rd_y),
    .wall_rd_valid (wall_rd_valid),
    .wall_rd_open  (wall_rd_open),
    .char_x        (char_x),
    .char_y        (char_y),
    .moved         (moved),
    .bumped        (bumped),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] m, input logic [CW*N-1:0] lx, input logic [CW*N-1:0] ly);
    load   = m;
    load_x = lx;
    load_y = ly;
    step(1);
    load   = '0;
  endtask

  initial begin
    reset       = 1'b1;
    maze_width  = 7'd8;
    maze_height = 7'd8;
    step_period = 28'd4;
    dir_req     = '0;
    load        = '0;
    load_x      = '0;
    load_y      = '0;
    step(3);
    chk("rst_char_x", 32'(char_x), 0);
    chk("rst_char_y", 32'(char_y), 0);
    chk("rst_req",    32'(wall_rd_req), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_pulses", 32'({moved, bumped}), 0);

    // 1: P0 walks right, one step every 4 clocks
    reset   = 1'b0;
    dir_req = 8'h01;
    step(4);
    chk("t1_req",   32'(wall_rd_req), 1);
    chk("t1_rdx",   32'(wall_rd_x), 1);
    chk("t1_busy",  32'(busy), 1);
    step(1);
    chk("t1_x1",    32'(char_x[6:0]), 1);
    chk("t1_mv1",   32'(moved), 32'h1);
    chk("t1_bump",  32'(bumped), 0);
    step(1);
    chk("t1_mv_pulse", 32'(moved), 0);
    step(1);
    chk("t1_noreq", 32'(wall_rd_req), 0);
    step(1);
    chk("t1_req2",  32'(wall_rd_x), 2);
    step(1);
    chk("t1_x2",    32'(char_x[6:0]), 2);
    chk("t1_mv2",   32'(moved), 32'h1);

    // 2: right edge of a 3-wide maze
    maze_width = 7'd3;
    do_load(2'b01, 14'd2, 14'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_noreq_wait", 32'(wall_rd_req), 0);
    end
    step(1);
`ifdef AVATAR_WRAP_EN
    chk("t2w_req",  32'(wall_rd_req), 1);
    chk("t2w_rdx",  32'(wall_rd_x), 0);
    step(1);
    chk("t2w_x",    32'(char_x[6:0]), 0);
    chk("t2w_mv",   32'(moved), 32'h1);
`else
    chk("t2_bump1", 32'(bumped), 32'h1);
    chk("t2_x",     32'(char_x[6:0]), 2);
    chk("t2_noreq", 32'(wall_rd_req), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_quiet", 32'({wall_rd_req, moved, bumped}), 0);
    end
    step(1);
    chk("t2_bump2", 32'(bumped), 32'h1);
    chk("t2_x2",    32'(char_x[6:0]), 2);
`endif

    // 3: wall at (1,0) blocks a move from (0,0)
    maze_width = 7'd8;
    wall_en    = 1'b1;
    wall_x     = 7'd1;
    wall_y     = 7'd0;
    do_load(2'b01, 14'd0, 14'd0);
    step(4);
    chk("t3_req",  32'(wall_rd_req), 1);
    chk("t3_rdx",  32'(wall_rd_x), 1);
    step(1);
    chk("t3_bump", 32'(bumped), 32'h1);
    chk("t3_mv",   32'(moved), 0);
    chk("t3_x",    32'(char_x[6:0]), 0);
    wall_en = 1'b0;

    // 4: simultaneous ticks, valid delay 3; last grant was P0 so P1 goes first
    step_period = 28'd20;
    vdelay      = 3;
    dir_req     = 8'h41;
    do_load(2'b11, {7'd4, 7'd0}, 14'd0);
    step(20);
    chk("t4_first_rd", 32'({wall_rd_req, wall_rd_x, wall_rd_y}), 32'({1'b1, 7'd4, 7'd1}));
    chk("t4_busy",     32'(busy), 1);
    step(3);
    chk("t4_p1_mv",    32'(moved), 32'h2);
    chk("t4_p1_y",     32'(char_y[13:7]), 1);
    step(1);
    chk("t4_second_rd", 32'({wall_rd_req, wall_rd_x, wall_rd_y}), 32'({1'b1, 7'd1, 7'd0}));
    step(3);
    chk("t4_p0_mv",    32'(moved), 32'h1);
    chk("t4_p0_x",     32'(char_x[6:0]), 1);
    step(1);
    chk("t4_idle",     32'(busy), 0);
    dir_req = 8'h40;
    step(12);
    chk("t4_solo_rd",  32'({wall_rd_x, wall_rd_y}), 32'({7'd4, 7'd2}));
    step(3);
    chk("t4_solo_mv",  32'(moved), 32'h2);
    // P1 was last granted, so the next simultaneous pair starts with P0
    dir_req = 8'h41;
    do_load(2'b11, {7'd4, 7'd0}, 14'd0);
    step(20);
    chk("t4_rr_first", 32'({wall_rd_x, wall_rd_y}), 32'({7'd1, 7'd0}));
    step(3);
    chk("t4_rr_mv0",   32'(moved), 32'h1);
    step(1);
    chk("t4_rr_second", 32'({wall_rd_x, wall_rd_y}), 32'({7'd4, 7'd1}));
    step(3);
    chk("t4_rr_mv1",   32'(moved), 32'h2);

    // 5: up+right held -> only y moves; then up from row 0
    vdelay      = 0;
    step_period = 28'd4;
    dir_req     = 8'h09;
    do_load(2'b01, 14'd3, 14'd1);
    step(4);
    chk("t5_rd",  32'({wall_rd_req, wall_rd_x, wall_rd_y}), 32'({1'b1, 7'd3, 7'd0}));
    step(1);
    chk("t5_pos", 32'({char_x[6:0], char_y[6:0]}), 32'({7'd3, 7'd0}));
    chk("t5_mv",  32'(moved), 32'h1);
    step(3);
`ifdef AVATAR_WRAP_EN
    chk("t5w_rd", 32'({wall_rd_req, wall_rd_x, wall_rd_y}), 32'({1'b1, 7'd3, 7'd7}));
    step(1);
    chk("t5w_y",  32'(char_y[6:0]), 7);
`else
    chk("t5_bump",  32'(bumped), 32'h1);
    chk("t5_noreq", 32'(wall_rd_req), 0);
    chk("t5_y",     32'(char_y[6:0]), 0);
`endif

    // 6: load during an in-flight lookup discards its result
    vdelay  = 3;
    dir_req = 8'h01;
    do_load(2'b01, 14'd0, 14'd0);
    step(4);
    chk("t6_req", 32'({wall_rd_req, wall_rd_x}), 32'({1'b1, 7'd1}));
    dir_req = 8'h00;
    do_load(2'b01, 14'd5, 14'd5);
    chk("t6_pos",    32'({char_x[6:0], char_y[6:0]}), 32'({7'd5, 7'd5}));
    chk("t6_busy1",  32'(busy), 1);
    step(1);
    chk("t6_busy2",  32'({busy, wall_rd_req}), 32'h3);
    chk("t6_quiet1", 32'({moved, bumped}), 0);
    step(1);
    chk("t6_done",   32'({busy, wall_rd_req}), 0);
    chk("t6_quiet2", 32'({moved, bumped}), 0);
    chk("t6_pos2",   32'({char_x[6:0], char_y[6:0]}), 32'({7'd5, 7'd5}));

    // 7: reset in the middle of a lookup
    dir_req = 8'h01;
    do_load(2'b01, 14'd0, 14'd0);
    step(4);
    chk("t7_req", 32'(wall_rd_req), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t7_drop", 32'({wall_rd_req, busy}), 0);
    chk("t7_pos",  32'(char_x), 0);
    step(3);
    chk("t7_quiet", 32'({wall_rd_req, moved, bumped}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
